// File: rtl/micro_sequencer_if.sv
// Micro-sequencer bus: micro-ROM word fields, condition inputs and status outputs.
interface micro_sequencer_if;
  logic        start;
  logic [2:0]  seq_ctrl;
  logic [5:0]  next_field;
  logic [5:0]  uadr_dispatch;
  logic        flag_z;
  logic        flag_n;
  logic        mem_ready;
  logic        alu_done;
  logic [5:0]  upc;
  logic        running;
  logic        halted;
  logic        stall;
  logic        instr_start;
  logic        err;
  logic [15:0] instr_count;

  // Controller / datapath side that feeds the sequencer and observes its status.
  modport master (
    output start, seq_ctrl, next_field, uadr_dispatch,
           flag_z, flag_n, mem_ready, alu_done,
    input  upc, running, halted, stall, instr_start, err, instr_count
  );

  // Sequencer side.
  modport slave (
    input  start, seq_ctrl, next_field, uadr_dispatch,
           flag_z, flag_n, mem_ready, alu_done,
    output upc, running, halted, stall, instr_start, err, instr_count
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: selects the next micro-address from the current
// micro-word's sequencing code, counts dispatched instructions and halts on
// the IDLE entry, on a null dispatch or on a wait that never completes.
module micro_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  micro_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] SC_NEXT     = 3'd0;
  localparam logic [2:0] SC_JUMP     = 3'd1;
  localparam logic [2:0] SC_DISPATCH = 3'd2;
  localparam logic [2:0] SC_FETCH    = 3'd3;
  localparam logic [2:0] SC_BRZ      = 3'd4;
  localparam logic [2:0] SC_BRN      = 3'd5;
  localparam logic [2:0] SC_WAITMEM  = 3'd6;
  localparam logic [2:0] SC_WAITALU  = 3'd7;

  localparam logic [5:0] UADR_NULL = 6'd0;
  localparam logic [5:0] UADR_IDLE = 6'd34;
  localparam logic [7:0] WAIT_MAX  = 8'hFF;

  logic [1:0]  state_q, state_d;
  logic [5:0]  upc_q, upc_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;

  logic        in_run;
  logic        stall_c;
  logic        dispatch_ok;
  logic [5:0]  upc_inc;

  assign in_run  = (state_q == ST_RUN);
  assign upc_inc = upc_q + 6'd1;

  // Stall and dispatch-pulse decode; condition inputs only matter under their own code in RUN.
  always_comb begin
    stall_c     = 1'b0;
    dispatch_ok = 1'b0;
    if (in_run) begin
      stall_c = ((bus.seq_ctrl == SC_WAITMEM) && !bus.mem_ready) ||
                ((bus.seq_ctrl == SC_WAITALU) && !bus.alu_done);
      dispatch_ok = (bus.seq_ctrl == SC_DISPATCH) && (bus.uadr_dispatch != UADR_NULL);
    end
  end

  // Next-state, next-address, wait-counter, instruction-count and error logic.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    count_d = count_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_STOP, ST_HALT: begin
        if (bus.start) begin
          state_d = ST_RUN;
          upc_d   = 6'd0;
          wait_d  = 8'd0;
        end
      end
      ST_RUN: begin
        if (stall_c) begin
          if (wait_q == WAIT_MAX) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d = 8'd0;
          case (bus.seq_ctrl)
            SC_NEXT:  upc_d = upc_inc;
            SC_JUMP:  upc_d = bus.next_field;
            SC_DISPATCH: begin
              if (bus.uadr_dispatch == UADR_NULL) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
                upc_d   = 6'd0;
              end else begin
                upc_d   = bus.uadr_dispatch;
                count_d = count_q + 16'd1;
                if (bus.uadr_dispatch == UADR_IDLE) begin
                  state_d = ST_HALT;
                end
              end
            end
            SC_FETCH:   upc_d = 6'd0;
            SC_BRZ:     upc_d = bus.flag_z ? bus.next_field : upc_inc;
            SC_BRN:     upc_d = bus.flag_n ? bus.next_field : upc_inc;
            SC_WAITMEM: upc_d = upc_inc;
            SC_WAITALU: upc_d = upc_inc;
          endcase
        end
      end
      default: begin
        state_d = ST_STOP;
        upc_d   = 6'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      upc_q   <= 6'd0;
      count_q <= 16'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign bus.upc         = upc_q;
  assign bus.running     = in_run;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.stall       = stall_c;
  assign bus.instr_start = dispatch_ok;
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural reference model.
module tb_micro_sequencer;

  logic clk;
  logic rst_n;

  micro_sequencer_if bus();

  micro_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: plain booleans and integers following the sequencing rules.
  bit m_run;
  bit m_halt;
  bit m_err;
  int m_upc;
  int m_cnt;
  int m_wait;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_stall();
    return m_run && (((bus.seq_ctrl == 3'd6) && !bus.mem_ready) ||
                     ((bus.seq_ctrl == 3'd7) && !bus.alu_done));
  endfunction

  function automatic bit model_istart();
    return m_run && (bus.seq_ctrl == 3'd2) && (bus.uadr_dispatch != 6'd0);
  endfunction

  task automatic model_halt();
    m_run  = 1'b0;
    m_halt = 1'b1;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit stalled;
    stalled = model_stall();
    if (!rst_n) begin
      m_run = 0; m_halt = 0; m_err = 0; m_upc = 0; m_cnt = 0; m_wait = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_halt = 0; m_upc = 0; m_wait = 0;
      end
    end else if (stalled) begin
      if (m_wait == 255) begin
        m_err = 1;
        model_halt();
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      case (bus.seq_ctrl)
        3'd0: m_upc = (m_upc + 1) % 64;
        3'd1: m_upc = int'(bus.next_field);
        3'd2: begin
          if (bus.uadr_dispatch == 6'd0) begin
            m_err = 1;
            m_upc = 0;
            model_halt();
          end else begin
            m_cnt = (m_cnt + 1) % 65536;
            m_upc = int'(bus.uadr_dispatch);
            if (bus.uadr_dispatch == 6'd34) model_halt();
          end
        end
        3'd3: m_upc = 0;
        3'd4: m_upc = bus.flag_z ? int'(bus.next_field) : (m_upc + 1) % 64;
        3'd5: m_upc = bus.flag_n ? int'(bus.next_field) : (m_upc + 1) % 64;
        default: m_upc = (m_upc + 1) % 64;
      endcase
    end
  endtask

  task automatic check_output();
    logic [15:0] exp_upc;
    logic [15:0] exp_cnt;
    exp_upc = 16'(m_upc);
    exp_cnt = 16'(m_cnt);
    check_val("upc",         {10'd0, bus.upc},   exp_upc);
    check_val("running",     {15'd0, bus.running},     {15'd0, m_run});
    check_val("halted",      {15'd0, bus.halted},      {15'd0, m_halt});
    check_val("stall",       {15'd0, bus.stall},       {15'd0, model_stall()});
    check_val("instr_start", {15'd0, bus.instr_start}, {15'd0, model_istart()});
    check_val("err",         {15'd0, bus.err},         {15'd0, m_err});
    check_val("instr_count", bus.instr_count,          exp_cnt);
  endtask

  // One clock: check at the falling edge, then take the rising edge in DUT and model.
  task automatic step_cycle();
    @(negedge clk);
    check_output();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] sc, input logic [5:0] nf, input logic [5:0] ud,
                                input logic fz, input logic fn, input logic mr,
                                input logic ad, input logic st);
    bus.seq_ctrl      = sc;
    bus.next_field    = nf;
    bus.uadr_dispatch = ud;
    bus.flag_z        = fz;
    bus.flag_n        = fn;
    bus.mem_ready     = mr;
    bus.alu_done      = ad;
    bus.start         = st;
  endtask

  task automatic do_start();
    rst_n = 1'b1;
    apply_stimulus(3'd0, 6'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    $display("[TB] micro_sequencer bench starting");
    rst_n = 1'b0;
    apply_stimulus(3'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    // start held high during reset must be ignored
    step_cycle();
    step_cycle();
    check_val("rst_upc", {10'd0, bus.upc}, 16'd0);
    check_val("rst_running", {15'd0, bus.running}, 16'd0);

    // Scenario 1: sequential stepping with wrap at 64
    do_start();
    check_val("s1_running", {15'd0, bus.running}, 16'd1);
    apply_stimulus(3'd0, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (70) step_cycle();
    check_val("s1_upc_wrap", {10'd0, bus.upc}, 16'd6);

    // Scenario 2: conditional branches from upc=3
    apply_stimulus(3'd1, 6'd3, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    apply_stimulus(3'd4, 6'd17, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    check_val("s2_brz_taken", {10'd0, bus.upc}, 16'd17);
    apply_stimulus(3'd1, 6'd3, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    apply_stimulus(3'd4, 6'd17, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step_cycle();
    check_val("s2_brz_not", {10'd0, bus.upc}, 16'd4);
    apply_stimulus(3'd1, 6'd3, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    apply_stimulus(3'd5, 6'd17, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step_cycle();
    check_val("s2_brn_taken", {10'd0, bus.upc}, 16'd17);

    // Scenario 3: dispatch, then IDLE dispatch halts, then restart
    apply_stimulus(3'd2, 6'd0, 6'd23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    check_val("s3_upc", {10'd0, bus.upc}, 16'd23);
    check_val("s3_count", bus.instr_count, 16'd1);
    apply_stimulus(3'd2, 6'd0, 6'd34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    check_val("s3_idle_halted", {15'd0, bus.halted}, 16'd1);
    check_val("s3_idle_upc", {10'd0, bus.upc}, 16'd34);
    check_val("s3_idle_count", bus.instr_count, 16'd2);
    step_cycle();
    do_start();
    check_val("s3_restart_upc", {10'd0, bus.upc}, 16'd0);
    check_val("s3_restart_run", {15'd0, bus.running}, 16'd1);

    // Scenario 4: memory wait for five cycles
    apply_stimulus(3'd1, 6'd20, 6'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step_cycle();
    apply_stimulus(3'd6, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) step_cycle();
    check_val("s4_held", {10'd0, bus.upc}, 16'd20);
    bus.mem_ready = 1'b1;
    #1;
    check_val("s4_stall_released", {15'd0, bus.stall}, 16'd0);
    step_cycle();
    check_val("s4_advance", {10'd0, bus.upc}, 16'd21);

    // Scenario 5: ALU wait never completes
    apply_stimulus(3'd1, 6'd10, 6'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step_cycle();
    apply_stimulus(3'd7, 6'd0, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (255) step_cycle();
    check_val("s5_not_yet", {15'd0, bus.halted}, 16'd0);
    step_cycle();
    check_val("s5_err", {15'd0, bus.err}, 16'd1);
    check_val("s5_halted", {15'd0, bus.halted}, 16'd1);
    check_val("s5_upc", {10'd0, bus.upc}, 16'd10);
    step_cycle();
    do_start();
    check_val("s5_restart_err", {15'd0, bus.err}, 16'd1);
    check_val("s5_restart_run", {15'd0, bus.running}, 16'd1);

    // Scenario 6: reset during a stall, then null dispatch
    apply_stimulus(3'd2, 6'd0, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    bus.uadr_dispatch = 6'd6;  step_cycle();
    bus.uadr_dispatch = 6'd40; step_cycle();
    check_val("s6_count5", bus.instr_count, 16'd5);
    check_val("s6_upc40", {10'd0, bus.upc}, 16'd40);
    apply_stimulus(3'd6, 6'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step_cycle();
    rst_n = 1'b0;
    bus.start = 1'b1;
    step_cycle();
    check_val("s6_rst_upc", {10'd0, bus.upc}, 16'd0);
    check_val("s6_rst_count", bus.instr_count, 16'd0);
    check_val("s6_rst_err", {15'd0, bus.err}, 16'd0);
    check_val("s6_rst_stop", {14'd0, bus.running, bus.halted}, 16'd0);
    do_start();
    apply_stimulus(3'd2, 6'd0, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step_cycle();
    bus.uadr_dispatch = 6'd0; step_cycle();
    check_val("s6_null_err", {15'd0, bus.err}, 16'd1);
    check_val("s6_null_halted", {15'd0, bus.halted}, 16'd1);
    check_val("s6_null_count", bus.instr_count, 16'd1);
    check_val("s6_null_upc", {10'd0, bus.upc}, 16'd0);
    step_cycle();

    // Randomized run with occasional restarts and resets
    for (int i = 0; i < 3000; i++) begin
      bus.seq_ctrl      = 3'($urandom_range(0, 7));
      bus.next_field    = 6'($urandom_range(0, 63));
      bus.uadr_dispatch = 6'($urandom_range(0, 63));
      bus.flag_z        = 1'($urandom_range(0, 1));
      bus.flag_n        = 1'($urandom_range(0, 1));
      bus.mem_ready     = ($urandom_range(0, 3) != 0);
      bus.alu_done      = ($urandom_range(0, 3) != 0);
      bus.start         = ($urandom_range(0, 5) == 0);
      rst_n             = ($urandom_range(0, 299) != 0);
      step_cycle();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
